// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   sa_state_e       : FSM state encoding (2'b11 is unused and treated as IDLE)
//   SA_WIDTH_DEFAULT : default operand/result width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } sa_state_e;

  localparam int SA_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/Full_adder.sv
// One-bit full-adder cell.
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module Full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built around a single one-bit full-adder cell.
// One operand bit pair is added per clock, LSB first, with the carry held in
// a flop between bits.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request, sampled only in IDLE
//   a, b, cin    : operands and carry-in, captured on the accepting edge
//   busy         : high whenever not IDLE
//   done         : one-cycle pulse, result valid from this cycle
//   sum, cout    : registered result, held until the next completion
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_sum, fa_cout;

  Full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      SHIFT: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        // Sum bits enter at the MSB so after WIDTH shifts bit 0 is the LSB.
        acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          sum_d   = {fa_sum, acc_q[WIDTH-1:1]};
          cout_d  = fa_cout;
        end
      end
      DONE: state_d = IDLE;
      // IDLE and the unused encoding both behave as IDLE.
      default: begin
        state_d = IDLE;
        if (start) begin
          state_d = SHIFT;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // Decoded from registered state only, so both are glitch-free.
  assign busy = (state_q == SHIFT) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed vector table plus
// hand-written sequences for reset, busy guard, mid-op reset and a
// continuous-start random regression.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int tests = 0;
  int fails = 0;

  // results of the last run_op
  int r_lat, r_busy, r_done;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[10];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request, then observe at each falling edge until busy drops.
  // k counts falling edges after the accepting edge; inj>=0 pulses a
  // second start (a=8'h10) at falling edge inj.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input int inj);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'b1;
    r_lat = -1; r_busy = 0; r_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == inj) begin start = 1'b1; a = 8'h10; end
      else if (k == inj + 1) start = 1'b0;
      if (busy) r_busy++;
      if (done) begin
        r_done++;
        if (r_lat < 0) r_lat = k;
      end
      if (!busy) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [8:0] expv;
    logic [8:0] lastres;
    int ndone, last_cyc, cyc;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[3] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[8] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[9] = '{8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1};

    // Reset with random inputs and start asserted: outputs stay cleared.
    rst_n = 1'b0; start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("reset_outputs", {21'd0, busy, done, cout, sum}, 32'd0);
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    rst_n = 1'b1;

    // Directed vectors.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, -1);
      chk($sformatf("vec%0d_sum", i), {24'd0, sum}, {24'd0, vecs[i].exp_sum});
      chk($sformatf("vec%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].exp_cout});
      chk($sformatf("vec%0d_latency", i), r_lat, W);
      chk($sformatf("vec%0d_busy_cycles", i), r_busy, W + 1);
      chk($sformatf("vec%0d_done_pulses", i), r_done, 1);
    end

    // Result holds while idle.
    repeat (5) @(negedge clk);
    chk("hold_sum", {23'd0, cout, sum}, {23'd0, 1'b1, 8'h2D});

    // Busy guard: second start mid-SHIFT is dropped.
    run_op(8'h03, 8'h04, 1'b0, 3);
    chk("guard_sum", {23'd0, cout, sum}, {23'd0, 1'b0, 8'h07});
    chk("guard_done_pulses", r_done, 1);
    repeat (3) @(negedge clk);
    chk("guard_no_restart", {31'd0, busy}, 32'd0);

    // Reset asserted right after shift edge 4 aborts the operation.
    @(negedge clk);
    a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("abort_cleared", {21'd0, busy, done, cout, sum}, 32'd0);
    r_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) r_done++;
    end
    chk("abort_no_done", r_done, 0);
    rst_n = 1'b1;
    run_op(8'h22, 8'h11, 1'b0, -1);
    chk("post_abort_sum", {23'd0, cout, sum}, {23'd0, 1'b0, 8'h33});
    chk("post_abort_latency", r_lat, W);

    // Random regression with start held continuously.
    @(negedge clk);
    start = 1'b1;
    ndone = 0; last_cyc = -1; cyc = 0; expv = '0; lastres = '0;
    while (ndone < 1000 && cyc < 20000) begin
      if (done) begin
        chk("rand_result", {23'd0, cout, sum}, {23'd0, expv});
        if (last_cyc >= 0) chk("rand_spacing", cyc - last_cyc, W + 2);
        last_cyc = cyc;
        lastres = expv;
        ndone++;
      end else if (!busy) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
        expv = 9'(a) + 9'(b) + 9'(cin);
      end
      if (ndone < 1000) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("rand_op_count", ndone, 1000);
    repeat (6) @(negedge clk);
    chk("rand_final_hold", {23'd0, cout, sum}, {23'd0, lastres});
    chk("rand_final_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
